// File: rtl/softmax_vec_buffer_ctrl_pkg.sv
// Shared definitions for the softmax vector buffer controller and its skid buffer.
package softmax_vec_buffer_ctrl_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int ADDR_WIDTH_DEF  = 10;
  localparam int TOTAL_WORDS_DEF = 1024;

  localparam logic [DATA_WIDTH_DEF-1:0] MOST_NEG_DEF = {1'b1, {(DATA_WIDTH_DEF-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/softmax_skid_buf.sv
// Two-entry valid/ready buffer; the head entry is a register and drives the
// output directly, so the output stays stable while the consumer stalls.
module softmax_skid_buf #(
  parameter int WIDTH = 33
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             pop;

  assign pop       = pop_valid && pop_ready;
  assign pop_valid = (count != 2'd0);
  assign pop_data  = head;

  // Storage and occupancy update; head always holds the oldest entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else if (clear) begin
      count <= 2'd0;
    end else begin
      case ({push_valid, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) head <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/softmax_vec_buffer_ctrl.sv
// Softmax vector front-end: captures a streamed vector into single-port RAM while
// tracking its signed max, then replays it in order through a 2-entry skid buffer.
module softmax_vec_buffer_ctrl
  import softmax_vec_buffer_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int TOTAL_WORDS = TOTAL_WORDS_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] max_value,
  output logic [ADDR_WIDTH:0]   vec_len,
  output logic                  overflow,
  output logic                  ram_enable,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int                  CW        = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]       LAST_SLOT = CW'(TOTAL_WORDS - 1);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                state;
  state_t                next_state;
  logic                  armed;
  logic [CW-1:0]         wr_ptr;
  logic [CW-1:0]         rd_ptr;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic                  inflight;
  logic                  inflight_last;
  logic                  accept;
  logic                  issue;
  logic                  pop;
  logic                  fill_done;
  logic                  drain_done;
  logic [1:0]            buf_count;
  logic [2:0]            occupancy;
  logic [2:0]            credit_limit;
  logic [DATA_WIDTH:0]   buf_head;

  assign accept       = (state == ST_FILL) && armed && in_valid;
  assign fill_done    = accept && (in_last || (wr_ptr == LAST_SLOT));
  assign pop          = out_valid && out_ready;
  assign drain_done   = pop && out_last;
  // Reads already issued or buffered must never exceed the two skid slots.
  assign occupancy    = {1'b0, buf_count} + {2'b00, inflight};
  assign credit_limit = 3'd2 + {2'b00, pop};
  assign issue        = (state == ST_DRAIN) && (rd_ptr < vec_len) && (occupancy < credit_limit);
  assign out_data     = buf_head[DATA_WIDTH-1:0];
  assign out_last     = buf_head[DATA_WIDTH];

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_FILL;
    else       state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      ST_FILL:  next_state = fill_done  ? ST_DRAIN : ST_FILL;
      ST_DRAIN: next_state = drain_done ? ST_FILL  : ST_DRAIN;
      default:  next_state = ST_FILL;
    endcase
  end

  // RAM port and input handshake decode.
  always_comb begin
    in_ready     = 1'b0;
    ram_enable   = 1'b0;
    write_enable = 1'b0;
    address      = addr_hold;
    ram_wdata    = in_data;
    case (state)
      ST_FILL: begin
        in_ready = armed;
        if (accept) begin
          ram_enable   = 1'b1;
          write_enable = 1'b1;
          address      = wr_ptr[ADDR_WIDTH-1:0];
        end else begin
          ram_enable = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (issue) begin
          ram_enable = 1'b1;
          address    = rd_ptr[ADDR_WIDTH-1:0];
        end else begin
          ram_enable = 1'b0;
        end
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Pointers, running max, length, overflow flag and read-in-flight tracking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed         <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      addr_hold     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      max_value     <= MOST_NEG;
      vec_len       <= '0;
      overflow      <= 1'b0;
    end else begin
      armed    <= 1'b1;
      inflight <= issue;
      if (ram_enable) addr_hold <= address;
      if (accept) begin
        wr_ptr  <= wr_ptr + CW'(1);
        vec_len <= wr_ptr + CW'(1);
        if ((wr_ptr == '0) || ($signed(in_data) > $signed(max_value))) max_value <= in_data;
        if ((wr_ptr == LAST_SLOT) && !in_last) overflow <= 1'b1;
        else if (wr_ptr == '0)                 overflow <= 1'b0;
      end
      if (issue) begin
        rd_ptr        <= rd_ptr + CW'(1);
        inflight_last <= (rd_ptr == (vec_len - CW'(1)));
      end
      if (drain_done) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        inflight <= 1'b0;
      end
    end
  end

  softmax_skid_buf #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clock      (clock),
    .reset      (reset),
    .clear      (drain_done),
    .push_valid (inflight),
    .push_data  ({inflight_last, ram_rdata}),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (buf_head),
    .count      (buf_count)
  );

endmodule

// File: tb/tb_softmax_vec_buffer_ctrl.sv
// Randomised self-checking bench: a queue-based vector model predicts writes,
// replay order, max, length and overflow; a RAM model closes the loop.
module tb_softmax_vec_buffer_ctrl;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int TW = 16;
  localparam logic [DW-1:0] MOST_NEG = 32'h8000_0000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [DW-1:0] max_value;
  logic [AW:0]   vec_len;
  logic          overflow;
  logic          ram_enable;
  logic          write_enable;
  logic [AW-1:0] address;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] mem [TW];

  int total = 0;
  int bad   = 0;

  logic [DW:0]   exp_q[$];
  logic [DW-1:0] m_cur[$];
  logic [DW-1:0] m_max;
  int            m_len, m_cnt, m_age, m_rd_next, m_outst, m_pops, rel_neg, rdy_mode, phase;
  bit            m_ovf, m_drain, m_fresh, m_seen;

  always #5 clock = ~clock;

  softmax_vec_buffer_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TOTAL_WORDS(TW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .max_value(max_value), .vec_len(vec_len),
    .overflow(overflow), .ram_enable(ram_enable), .write_enable(write_enable),
    .address(address), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always @(posedge clock) begin
    if (ram_enable) begin
      if (write_enable) mem[address] <= ram_wdata;
      else              ram_rdata <= mem[address];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete(); m_cur.delete();
    m_max = MOST_NEG; m_len = 0; m_cnt = 0; m_ovf = 0; m_drain = 0; m_fresh = 1;
    m_seen = 0; m_age = 0; m_rd_next = 0; m_outst = 0; m_pops = 0;
  endtask

  task automatic monitor_step();
    bit          hs;
    logic [DW:0] head;
    if (reset) begin
      model_reset();
      rel_neg = 0;
      return;
    end
    rel_neg++;
    if (m_drain) m_age++;
    hs = in_valid && in_ready;
    check("in_ready", 64'(in_ready), 64'((rel_neg >= 2) && !m_drain));
    check("max_value", 64'(max_value), 64'(m_max));
    check("overflow", 64'(overflow), 64'(m_ovf));
    if (m_drain || m_fresh) check("vec_len", 64'(vec_len), 64'(m_len));
    if (hs) begin
      check("wr_port", 64'({ram_enable, write_enable}), 64'(2'b11));
      check("wr_addr", 64'(address), 64'(m_cnt[AW-1:0]));
      check("wr_data", 64'(ram_wdata), 64'(in_data));
      if (m_cnt == 0 || $signed(in_data) > $signed(m_max)) m_max = in_data;
      if (m_cnt == 0) m_ovf = 0;
      m_fresh = 0;
      m_cur.push_back(in_data);
      m_cnt++;
      if (in_last || m_cnt == TW) begin
        m_len = m_cnt;
        m_ovf = !in_last;
        foreach (m_cur[i]) exp_q.push_back({(i == m_cnt - 1) ? 1'b1 : 1'b0, m_cur[i]});
        m_drain = 1; m_age = 0; m_seen = 0; m_rd_next = 0; m_outst = 0; m_pops = 0;
      end
    end else begin
      check("no_stray_write", 64'(ram_enable && write_enable), 64'(0));
    end
    if (out_valid) begin
      if (m_drain && !m_seen) begin
        check("first_valid_latency", 64'(m_age), 64'(3));
        m_seen = 1;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'(out_valid), 64'(0));
      end else begin
        head = exp_q[0];
        check("out_data", 64'(out_data), 64'(head[DW-1:0]));
        check("out_last", 64'(out_last), 64'(head[DW]));
        if (out_ready) begin
          head = exp_q.pop_front();
          m_outst--; m_pops++;
          if (head[DW]) begin
            m_drain = 0; m_fresh = 1; m_cnt = 0; m_cur.delete();
          end
        end
      end
    end else if (m_drain && m_seen) begin
      check("valid_continuous", 64'(out_valid), 64'(1));
    end
    if (ram_enable && !write_enable) begin
      check("read_in_drain", 64'(m_drain), 64'(1));
      check("read_in_range", 64'(m_rd_next < m_len), 64'(1));
      check("read_addr", 64'(address), 64'(m_rd_next[AW-1:0]));
      m_rd_next++; m_outst++;
      check("outstanding_le_2", 64'(m_outst <= 2), 64'(1));
    end
  endtask

  task automatic send_word(input logic [DW-1:0] d, input bit last);
    bit hs;
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    do begin
      @(negedge clock); hs = in_ready;
      @(posedge clock); #1; n++;
    end while (!hs && n < 400);
    if (!hs) check("send_timeout", 64'(0), 64'(1));
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_vec(input logic [DW-1:0] v[$], input bit gaps);
    foreach (v[i]) begin
      send_word(v[i], i == v.size() - 1);
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (m_drain && n < 600) begin @(posedge clock); #1; n++; end
    if (m_drain) check("drain_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    logic [DW-1:0] v[$];
    int            n;
    model_reset();
    rel_neg = 0; rdy_mode = 0; phase = 0;
    fork
      forever begin @(negedge clock); monitor_step(); end
      forever begin
        @(posedge clock); #1;
        case (rdy_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = (phase % 3 == 0);
          2:       out_ready = 1'($urandom_range(0, 1));
          default: out_ready = 1'b1;
        endcase
        phase++;
      end
    join_none
    repeat (3) @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("reset_max", 64'(max_value), 64'(MOST_NEG));
    check("reset_vec_len", 64'(vec_len), 64'(0));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    @(posedge clock); #1;

    v = '{32'd5, 32'hFFFF_FFFD, 32'd12, 32'd7};
    send_vec(v, 0); wait_drain();
    check("t1_max", 64'(max_value), 64'(32'd12));
    check("t1_len", 64'(vec_len), 64'(5'd4));

    v = '{32'hFFFF_FF9C};
    send_vec(v, 0); wait_drain();
    check("t2_max", 64'(max_value), 64'(32'hFFFF_FF9C));
    check("t2_len", 64'(vec_len), 64'(5'd1));

    rdy_mode = 1; phase = 0;
    v.delete(); for (int i = 0; i < 8; i++) v.push_back($urandom);
    send_vec(v, 0); wait_drain();

    rdy_mode = 0;
    for (int i = 0; i < 16; i++) send_word(DW'(i + 1), 1'b0);
    check("t4_overflow", 64'(overflow), 64'(1));
    check("t4_len", 64'(vec_len), 64'(5'd16));
    in_valid = 1'b1; in_data = 32'd17;
    repeat (5) begin @(negedge clock); check("t4_held_off", 64'(in_ready), 64'(0)); end
    @(posedge clock); #1; in_valid = 1'b0;
    wait_drain();

    v = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60};
    send_vec(v, 0);
    n = 0;
    while (m_pops < 2 && n < 100) begin @(posedge clock); #1; n++; end
    check("t5_pops_reached", 64'(m_pops), 64'(2));
    reset = 1'b1; #1;
    check("t5_out_valid", 64'(out_valid), 64'(0));
    check("t5_out_data", 64'(out_data), 64'(0));
    check("t5_out_last", 64'(out_last), 64'(0));
    check("t5_max", 64'(max_value), 64'(MOST_NEG));
    check("t5_len", 64'(vec_len), 64'(0));
    check("t5_in_ready", 64'(in_ready), 64'(0));
    repeat (2) @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    v = '{32'd1, 32'd2};
    send_vec(v, 0); wait_drain();
    check("t5_new_max", 64'(max_value), 64'(32'd2));

    v = '{32'hFFFF_FFFF, 32'hFFFF_FFFE};
    send_vec(v, 0);
    check("t6_max_first", 64'(max_value), 64'(32'hFFFF_FFFF));
    v = '{32'd9};
    send_vec(v, 0); wait_drain();
    check("t6_max_second", 64'(max_value), 64'(32'd9));

    rdy_mode = 2;
    for (int k = 0; k < 8; k++) begin
      v.delete();
      n = $urandom_range(1, TW);
      for (int i = 0; i < n; i++) v.push_back($urandom);
      send_vec(v, 1); wait_drain();
    end

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
